aclock: RTL and testbench

- 24-hour digital alarm clock with BCD outputs HH:MM:SS.
- Time advances once per second, derived from the system clock by an internal divider (10 Hz clock by default).
- Current time and alarm time are loadable from the BCD inputs.
- A sticky Alarm output asserts when the running time reaches the armed alarm time and stays high until stopped.

---
 rtl/aclock.sv | 79 +++++++
 tb/tb_aclock.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/aclock.sv
// aclock: 24-hour BCD alarm clock; seconds advance once per CLK_PER_SEC cycles.
module aclock #(
  parameter int CLK_PER_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic       LD_time,
  input  logic       LD_alarm,
  input  logic       STOP_al,
  input  logic       AL_ON,
  output logic       Alarm,
  output logic [1:0] H_out1,
  output logic [3:0] H_out0,
  output logic [3:0] M_out1,
  output logic [3:0] M_out0,
  output logic [3:0] S_out1,
  output logic [3:0] S_out0
);
  localparam int DW = $clog2(CLK_PER_SEC);
  logic [DW-1:0] div_q;
  logic [1:0] h1_q, h1_d, ah1_q;
  logic [3:0] h0_q, m1_q, m0_q, s1_q, s0_q;
  logic [3:0] h0_d, m1_d, m0_d, s1_d, s0_d;
  logic [3:0] ah0_q, am1_q, am0_q;
  logic       alarm_q, alarm_d;
  logic       in_ok, ld_t, ld_a, tick, match;
  logic       c_s0, c_s, c_m0, c_m, c_h0, c_day;
  assign in_ok = (H_in1 < 2'd2 ? H_in0 <= 4'd9 : H_in1 == 2'd2 && H_in0 <= 4'd3)
               && M_in1 <= 4'd5 && M_in0 <= 4'd9;
  assign ld_t = LD_time && in_ok;
  assign ld_a = LD_alarm && in_ok;
  assign tick = div_q == DW'(CLK_PER_SEC - 1);
  // BCD carry chain for the one-second increment
  always_comb begin
    c_s0  = s0_q == 4'd9;
    c_s   = c_s0 && s1_q == 4'd5;
    c_m0  = c_s && m0_q == 4'd9;
    c_m   = c_m0 && m1_q == 4'd5;
    c_day = c_m && h1_q == 2'd2 && h0_q == 4'd3;
    c_h0  = c_m && h0_q == 4'd9;
    s0_d  = c_s0 ? 4'd0 : s0_q + 4'd1;
    s1_d  = c_s ? 4'd0 : c_s0 ? s1_q + 4'd1 : s1_q;
    m0_d  = c_m0 ? 4'd0 : c_s ? m0_q + 4'd1 : m0_q;
    m1_d  = c_m ? 4'd0 : c_m0 ? m1_q + 4'd1 : m1_q;
    h0_d  = (c_day || c_h0) ? 4'd0 : c_m ? h0_q + 4'd1 : h0_q;
    h1_d  = c_day ? 2'd0 : c_h0 ? h1_q + 2'd1 : h1_q;
    match = tick && !ld_t && {h1_d, h0_d, m1_d, m0_d, s1_d, s0_d} == {ah1_q, ah0_q, am1_q, am0_q, 8'd0};
    alarm_d = (STOP_al || !AL_ON) ? 1'b0 : match ? 1'b1 : alarm_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {h1_q, h0_q, m1_q, m0_q} <= in_ok ? {H_in1, H_in0, M_in1, M_in0} : 14'd0;
      {s1_q, s0_q} <= 8'd0;
      div_q <= '0;
      {ah1_q, ah0_q, am1_q, am0_q} <= 14'd0;
      alarm_q <= 1'b0;
    end else begin
      if (ld_t) begin
        {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= {H_in1, H_in0, M_in1, M_in0, 8'd0};
      end else if (tick) begin
        {h1_q, h0_q, m1_q, m0_q, s1_q, s0_q} <= {h1_d, h0_d, m1_d, m0_d, s1_d, s0_d};
      end
      div_q <= (ld_t || tick) ? '0 : div_q + 1'b1;
      if (ld_a) {ah1_q, ah0_q, am1_q, am0_q} <= {H_in1, H_in0, M_in1, M_in0};
      alarm_q <= alarm_d;
    end
  end
  assign Alarm  = alarm_q;
  assign H_out1 = h1_q;
  assign H_out0 = h0_q;
  assign M_out1 = m1_q;
  assign M_out0 = m0_q;
  assign S_out1 = s1_q;
  assign S_out0 = s0_q;
endmodule

// File: tb/tb_aclock.sv
// tb_aclock: per-cycle scoreboard against a seconds-of-day model, plus table vectors and alarm sequences.
module tb_aclock;
  localparam int N = 10;
  logic clk = 0;
  logic reset = 0, ld_t = 0, ld_a = 0, stop = 0, al_on = 0;
  logic [1:0] h1 = 0, oh1;
  logic [3:0] h0 = 0, m1 = 0, m0 = 0, oh0, om1, om0, os1, os0;
  logic alarm;

  aclock #(.CLK_PER_SEC(N)) dut (
    .clk(clk), .reset(reset), .H_in1(h1), .H_in0(h0), .M_in1(m1), .M_in0(m0),
    .LD_time(ld_t), .LD_alarm(ld_a), .STOP_al(stop), .AL_ON(al_on), .Alarm(alarm),
    .H_out1(oh1), .H_out0(oh0), .M_out1(om1), .M_out0(om0), .S_out1(os1), .S_out0(os0)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       al;
    logic [1:0] h1;
    logic [3:0] h0, m1, m0, s1, s0;
  } obs_t;

  typedef struct {
    logic [1:0] h1;
    logic [3:0] h0, m1, m0;
    int ld, run, eh, em, es;
  } vec_t;

  obs_t sbq[$];
  vec_t vt[9];
  int checks = 0, errors = 0;
  int tod = 0, div = 0, al_min = 0;
  bit m_al = 0;

  function automatic obs_t to_obs(int t, bit a);
    obs_t o;
    int hh = t / 3600, mm = (t / 60) % 60, ss = t % 60;
    o.al = a;
    o.h1 = 2'(hh / 10); o.h0 = 4'(hh % 10);
    o.m1 = 4'(mm / 10); o.m0 = 4'(mm % 10);
    o.s1 = 4'(ss / 10); o.s0 = 4'(ss % 10);
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("%0d%0d:%0d%0d:%0d%0d al=%0d", o.h1, o.h0, o.m1, o.m0, o.s1, o.s0, o.al);
  endfunction

  function automatic obs_t dut_obs();
    return {alarm, oh1, oh0, om1, om0, os1, os0};
  endfunction

  task automatic chk(string name, obs_t exp);
    obs_t got = dut_obs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %s expected %s", name, $time, fmt(got), fmt(exp));
    end
  endtask

  task automatic ex(string name, int hh, int mm, int ss, bit a);
    chk(name, to_obs(hh * 3600 + mm * 60 + ss, a));
  endtask

  task automatic step();
    int hh = h1 * 10 + h0;
    int mm = m1 * 10 + m0;
    bit v = hh <= 23 && m1 <= 5 && m0 <= 9;
    bit tk, ldv;
    int nt;
    if (reset) begin
      tod = v ? (hh * 60 + mm) * 60 : 0;
      div = 0; al_min = 0; m_al = 0;
    end else begin
      tk = div == N - 1;
      ldv = ld_t && v;
      nt = ldv ? (hh * 60 + mm) * 60 : tk ? (tod + 1) % 86400 : tod;
      m_al = (stop || !al_on) ? 1'b0 : (tk && !ldv && nt == al_min * 60) ? 1'b1 : m_al;
      if (ld_a && v) al_min = hh * 60 + mm;
      div = (ldv || tk) ? 0 : div + 1;
      tod = nt;
    end
    sbq.push_back(to_obs(tod, m_al));
    @(posedge clk);
    #1;
    chk("cycle", sbq.pop_front());
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_in(logic [1:0] a, logic [3:0] b, logic [3:0] c, logic [3:0] d);
    h1 = a; h0 = b; m1 = c; m0 = d;
  endtask

  initial begin
    vt[0] = '{2'd2, 4'd3, 4'd5, 4'd9, 1, 600, 0, 0, 0};
    vt[1] = '{2'd0, 4'd9, 4'd5, 4'd9, 1, 600, 10, 0, 0};
    vt[2] = '{2'd1, 4'd9, 4'd5, 4'd9, 1, 600, 20, 0, 0};
    vt[3] = '{2'd1, 4'd2, 4'd3, 4'd4, 10, 0, 12, 34, 0};
    vt[4] = '{2'd2, 4'd5, 4'd0, 4'd0, 1, 599, 12, 35, 0};
    vt[5] = '{2'd1, 4'd2, 4'd6, 4'd0, 1, 9, 12, 35, 1};
    vt[6] = '{2'd3, 4'd0, 4'd0, 4'd0, 1, 9, 12, 35, 2};
    vt[7] = '{2'd1, 4'd2, 4'd3, 4'd10, 1, 9, 12, 35, 3};
    vt[8] = '{2'd0, 4'd0, 4'd5, 4'd9, 1, 600, 1, 0, 0};

    // reset with 10:14, then count
    reset = 1; set_in(1, 0, 1, 4);
    run(10);
    ex("reset_state", 10, 14, 0, 0);
    reset = 0;
    run(10);
    ex("first_tick", 10, 14, 1, 0);
    run(590);
    ex("one_minute", 10, 15, 0, 0);

    // alarm at 10:20
    set_in(1, 0, 2, 0); ld_a = 1; al_on = 1;
    run(1);
    ld_a = 0;
    run(2998);
    ex("pre_alarm", 10, 19, 59, 0);
    run(1);
    ex("alarm_rise", 10, 20, 0, 1);
    run(10);
    ex("alarm_sticky", 10, 20, 1, 1);
    stop = 1;
    run(1);
    ex("stop_clears", 10, 20, 1, 0);
    stop = 0;
    run(600);
    ex("stays_clear", 10, 21, 1, 0);

    al_on = 0;
    for (int i = 0; i < 9; i++) begin
      set_in(vt[i].h1, vt[i].h0, vt[i].m1, vt[i].m0);
      ld_t = 1;
      run(vt[i].ld);
      ld_t = 0;
      run(vt[i].run);
      ex($sformatf("vec%0d", i), vt[i].eh, vt[i].em, vt[i].es, 0);
    end

    // load held: frozen, then alarm 04:55 cleared by AL_ON=0
    set_in(0, 4, 4, 5); ld_t = 1;
    run(5);
    ex("ld_frozen", 4, 45, 0, 0);
    run(5);
    ld_t = 0;
    set_in(0, 4, 5, 5); ld_a = 1; al_on = 1;
    run(1);
    ld_a = 0;
    run(5998);
    ex("pre_alarm2", 4, 54, 59, 0);
    run(1);
    ex("alarm2_rise", 4, 55, 0, 1);
    al_on = 0;
    run(1);
    ex("al_on_clears", 4, 55, 0, 0);

    // simultaneous load of matching time/alarm does not trigger
    al_on = 1; set_in(0, 6, 0, 0); ld_t = 1; ld_a = 1;
    run(1);
    ld_t = 0; ld_a = 0;
    ex("no_false_trig", 6, 0, 0, 0);
    set_in(0, 6, 0, 1); ld_a = 1; al_on = 0;
    run(1);
    ld_a = 0;
    run(599);
    ex("al_off_match", 6, 1, 0, 0);
    set_in(0, 6, 0, 2); ld_a = 1; al_on = 1; stop = 1;
    run(1);
    ld_a = 0;
    run(599);
    ex("stop_at_match", 6, 2, 0, 0);
    stop = 0;
    run(10);
    ex("stop_released", 6, 2, 1, 0);

    // alarm survives loads, then reset clears it
    set_in(0, 6, 0, 3); ld_a = 1;
    run(1);
    ld_a = 0;
    run(589);
    ex("alarm3_rise", 6, 3, 0, 1);
    set_in(0, 7, 0, 0); ld_t = 1;
    run(1);
    ld_t = 0;
    ex("survive_ld_time", 7, 0, 0, 1);
    set_in(0, 8, 0, 0); ld_a = 1;
    run(1);
    ld_a = 0;
    ex("survive_ld_alarm", 7, 0, 0, 1);
    set_in(3, 0, 0, 0); reset = 1;
    run(1);
    reset = 0;
    ex("reset_invalid", 0, 0, 0, 0);
    set_in(2, 3, 5, 9); ld_t = 1;
    run(1);
    ld_t = 0;
    run(600);
    ex("reset_alarm_0000", 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
